clk_div_multi: RTL
==================

# clk_div_multi

Multi-channel programmable clock divider that generates slow square waves and matching single-cycle tick strobes from the system clock. It supersedes the fixed single-output divider. Each channel has a runtime-writable half-period and its own enable, so one instance can drive display scan, debounce sampling and the slow CPU step clock together. It sits at top level beside the board clock input and feeds slow-clock and strobe consumers.

## Interface
- NCH, 4, number of independent channels (1..16)
- WIDTH, 32, half-period counter/register width
- DEFAULT_DIV, 50_000_000, half-period loaded into every channel at reset (1 Hz from 100 MHz)
- CHW, localparam, NCH>1 ? $clog2(NCH) : 1

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  NCH  per-channel run enable
- wr_en  input  1  write strobe for half-period register
- wr_ch  input  CHW  target channel of write
- wr_data  input  WIDTH  new half-period value H
- clk_N  output  NCH  divided square waves, registered
- tick  output  NCH  one-cycle pulse on every clk_N toggle, registered

## Operation
- Per channel: active half-period register H, counter cnt (WIDTH bits), output bit clk_N[i], tick[i].
- Reset: all cnt=0, clk_N=0, tick=0, all H=DEFAULT_DIV. rst overrides en and wr_en in the same cycle.
- Channel states: IDLE (en=0 or H=0) and RUN (en=1 and H≠0).
- IDLE: cnt←0, clk_N←0, tick←0 at the next edge. A write still updates H.
- RUN, non-terminal (cnt < H−1): cnt←cnt+1, tick←0.
- RUN, terminal (cnt ≥ H−1): cnt←0, clk_N←~clk_N, tick←1.
- The ≥ compare makes a shrinking H end the current half-period at the next edge rather than wrapping through 2^WIDTH.
- Output period = 2·H clk cycles, duty cycle 50 %. H=1 gives clk/2 with tick high continuously.
- Write: when wr_en=1 and wr_ch<NCH, H[wr_ch] is updated (see Configuration for when). When wr_ch≥NCH, the write is ignored with no side effects.
- Channels are fully independent. A write to one channel never disturbs another.
- Leaving RUN mid-period discards the partial count. Re-entering RUN starts from cnt=0, clk_N=0.

## Timing
- Enable sampled high at edge E0 (cnt=0): the first terminal event occurs at edge E0+H−1. clk_N and tick are visible after that edge, i.e. H cycles after en is first seen.
- tick is high for exactly the one cycle in which clk_N has just changed, on both the rising and falling toggles.
- en deasserted: clk_N and tick are 0 one cycle later.
- Immediate-write mode: the new H is used by the compare in the cycle after the write edge.
- No combinational path from any input to clk_N or tick.

## Configuration
- CLKDIV_SHADOW_EN defined:
  - Each channel gets a shadow register S. Writes go to S.
  - S is copied to H at the channel's next terminal event, or immediately if the channel is IDLE.
  - A write coinciding with a terminal event loads wr_data directly into H at that edge.
  - Every half-period in progress completes at its old length, so there are no runt pulses.
  - Reset sets S=DEFAULT_DIV.
- CLKDIV_SHADOW_EN undefined:
  - No shadow registers. Writes update H at the write edge.
  - A half-period in progress may be shortened, per the ≥ rule.

## Test plan
- Reset with en=all-ones and no writes, held 10 cycles: clk_N=0, tick=0 throughout reset. After release, ch0 toggles for the first time 50_000_000 cycles later (run with DEFAULT_DIV=5 override: first toggle at cycle 5, period 10).
- Write ch0 H=3, en[0]=1 → clk_N[0] toggles every 3 cycles (period 6) and tick[0] pulses one cycle at each toggle. Write H=1 → clk_N[0] toggles every cycle and tick[0] stays high.
- Channel in RUN with H=8, en dropped at cnt=5 → clk_N=0 and tick=0 next cycle. Re-enable → first toggle after 8 cycles.
- H=10, cnt=7, write H=4:
  - Without macro: toggle at the next edge, then every 4 cycles.
  - With CLKDIV_SHADOW_EN: toggle 2 cycles later (old length completes), then every 4 cycles.
- Write H=0 to a running channel → channel goes IDLE with clk_N=0. Write H=2 → resumes with period 4.
- NCH=3, write wr_ch=3, data=1 → all three channels are unchanged in period and phase. Simultaneous writes to ch1 while ch2 runs → ch2 output is cycle-exact versus the model.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: per-channel half-period H, 50% square wave and toggle tick.
// Optional CLKDIV_SHADOW_EN: writes land in a shadow register applied at the next half-period boundary.
module clk_div_multi #(
  parameter int          NCH         = 4,
  parameter int          WIDTH       = 32,
  parameter int unsigned DEFAULT_DIV = 50_000_000,
  localparam int         CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   en,
  input  logic             wr_en,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [WIDTH-1:0] wr_data,
  output logic [NCH-1:0]   clk_N,
  output logic [NCH-1:0]   tick
);

  localparam logic [WIDTH-1:0] DEF_H = WIDTH'(DEFAULT_DIV);

  typedef enum logic {CH_IDLE, CH_RUN} ch_state_t;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] h_q, h_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wr_hit;
    logic             terminal;
    ch_state_t        state;

    // An out-of-range wr_ch can never equal a valid index, so it is ignored here.
    always_comb begin
      wr_hit   = wr_en && (wr_ch == CHW'(i));
      state    = (en[i] && (h_q != '0)) ? CH_RUN : CH_IDLE;
      terminal = (state == CH_RUN) && (cnt_q >= h_q - WIDTH'(1));
      cnt_d    = '0;
      clk_d    = 1'b0;
      tick_d   = 1'b0;
      if (state == CH_RUN) begin
        if (terminal) begin
          clk_d  = ~clk_q;
          tick_d = 1'b1;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
          clk_d = clk_q;
        end
      end
    end

`ifdef CLKDIV_SHADOW_EN
    logic [WIDTH-1:0] s_q, s_d;

    // H only changes on a half-period boundary (or while idle), so no runt pulses.
    always_comb begin
      s_d = wr_hit ? wr_data : s_q;
      h_d = h_q;
      if ((state == CH_IDLE) || terminal) begin
        h_d = wr_hit ? wr_data : s_q;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        s_q <= DEF_H;
      end else begin
        s_q <= s_d;
      end
    end
`else
    always_comb begin
      h_d = wr_hit ? wr_data : h_q;
    end
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q  <= '0;
        h_q    <= DEF_H;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        h_q    <= h_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end

    assign clk_N[i] = clk_q;
    assign tick[i]  = tick_q;
  end

endmodule
